// File: rtl/input_action_scheduler.sv
// Turns held/pressed key levels into serialised game actions with DAS/ARR and soft-drop repeat.
// Define REPEAT_ROTATE_EN to give rotate the same DAS/ARR repeat as left/right.
module input_action_scheduler #(
  parameter int DAS_TICKS  = 170,
  parameter int ARR_TICKS  = 50,
  parameter int SOFT_TICKS = 30,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       en,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_down,
  input  logic       key_rotate,
  input  logic       key_drop,
  output logic       act_valid,
  output logic [2:0] act_code,
  input  logic       act_ready
);

  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_e;

  localparam int IDX_LEFT   = 0;
  localparam int IDX_RIGHT  = 1;
  localparam int IDX_DOWN   = 2;
  localparam int IDX_ROTATE = 3;
  localparam int IDX_DROP   = 4;

  localparam logic [2:0] CODE_NONE   = 3'd0;
  localparam logic [2:0] CODE_LEFT   = 3'd1;
  localparam logic [2:0] CODE_RIGHT  = 3'd2;
  localparam logic [2:0] CODE_DOWN   = 3'd3;
  localparam logic [2:0] CODE_ROTATE = 3'd4;
  localparam logic [2:0] CODE_DROP   = 3'd5;

  localparam logic [CNT_W-1:0] DAS_LAST  = CNT_W'(DAS_TICKS - 1);
  localparam logic [CNT_W-1:0] ARR_LAST  = CNT_W'(ARR_TICKS - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_TICKS - 1);

  logic [4:0]       keys_w, press_w, events_w, grant_w;
  logic [4:0]       prev_q, pending_q, pending_d;
  dir_e             dir_q, dir_d;
  logic [CNT_W-1:0] lr_cnt_q, lr_cnt_d, dn_cnt_q, dn_cnt_d;
  logic             lr_das_q, lr_das_d;
  logic             lr_rep, dn_rep, rot_rep;
  logic             act_valid_q, act_valid_d;
  logic [2:0]       act_code_q, act_code_d;

  assign keys_w  = {key_drop, key_rotate, key_down, key_right, key_left};
  assign press_w = keys_w & ~prev_q;

  // Left/right: the most recently pressed key owns the shared DAS/ARR counter.
  always_comb begin : lr_next
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    dir_d    = dir_q;
    lr_cnt_d = lr_cnt_q;
    lr_das_d = lr_das_q;
    lr_rep   = 1'b0;
    if (press_w[IDX_RIGHT]) begin
      dir_d    = DIR_RIGHT;
      lr_cnt_d = '0;
      lr_das_d = 1'b0;
    end else if (press_w[IDX_LEFT]) begin
      dir_d    = DIR_LEFT;
      lr_cnt_d = '0;
      lr_das_d = 1'b0;
    end else if (dir_q == DIR_LEFT && !key_left) begin
      dir_d    = key_right ? DIR_RIGHT : DIR_NONE;
      lr_cnt_d = '0;
      lr_das_d = 1'b0;
    end else if (dir_q == DIR_RIGHT && !key_right) begin
      dir_d    = key_left ? DIR_LEFT : DIR_NONE;
      lr_cnt_d = '0;
      lr_das_d = 1'b0;
    end else if (dir_q != DIR_NONE && tick) begin
      if (lr_cnt_q == (lr_das_q ? ARR_LAST : DAS_LAST)) begin
        lr_rep   = 1'b1;
        lr_cnt_d = '0;
        lr_das_d = 1'b1;
      end else begin
        lr_cnt_d = lr_cnt_q + 1'b1;
      end
    end
    if (!en) begin
      dir_d    = DIR_NONE;
      lr_cnt_d = '0;
      lr_das_d = 1'b0;
      lr_rep   = 1'b0;
    end
  end

  always_comb begin : down_next
    dn_cnt_d = dn_cnt_q;
    dn_rep   = 1'b0;
    if (!en || !key_down || press_w[IDX_DOWN]) begin
      dn_cnt_d = '0;
    end else if (tick) begin
      if (dn_cnt_q == SOFT_LAST) begin
        dn_rep   = 1'b1;
        dn_cnt_d = '0;
      end else begin
        dn_cnt_d = dn_cnt_q + 1'b1;
      end
    end
  end

`ifdef REPEAT_ROTATE_EN
  logic [CNT_W-1:0] rot_cnt_q, rot_cnt_d;
  logic             rot_das_q, rot_das_d;

  always_comb begin : rot_next
    rot_cnt_d = rot_cnt_q;
    rot_das_d = rot_das_q;
    rot_rep   = 1'b0;
    if (!en || !key_rotate || press_w[IDX_ROTATE]) begin
      rot_cnt_d = '0;
      rot_das_d = 1'b0;
    end else if (tick) begin
      if (rot_cnt_q == (rot_das_q ? ARR_LAST : DAS_LAST)) begin
        rot_rep   = 1'b1;
        rot_cnt_d = '0;
        rot_das_d = 1'b1;
      end else begin
        rot_cnt_d = rot_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rot_cnt_q <= '0;
      rot_das_q <= 1'b0;
    end else begin
      rot_cnt_q <= rot_cnt_d;
      rot_das_q <= rot_das_d;
    end
  end
`else
  assign rot_rep = 1'b0;
`endif

  // A repeat and a press on the same key in one cycle merge via the OR.
  assign events_w = en ? (press_w | {1'b0, rot_rep, dn_rep,
                                     lr_rep && (dir_q == DIR_RIGHT),
                                     lr_rep && (dir_q == DIR_LEFT)})
                       : 5'b0;

  always_comb begin : out_next
    grant_w     = '0;
    act_valid_d = act_valid_q;
    act_code_d  = act_code_q;
    if (!act_valid_q || act_ready) begin
      act_valid_d = 1'b1;
      if (pending_q[IDX_DROP]) begin
        grant_w[IDX_DROP] = 1'b1;
        act_code_d        = CODE_DROP;
      end else if (pending_q[IDX_ROTATE]) begin
        grant_w[IDX_ROTATE] = 1'b1;
        act_code_d          = CODE_ROTATE;
      end else if (pending_q[IDX_LEFT]) begin
        grant_w[IDX_LEFT] = 1'b1;
        act_code_d        = CODE_LEFT;
      end else if (pending_q[IDX_RIGHT]) begin
        grant_w[IDX_RIGHT] = 1'b1;
        act_code_d         = CODE_RIGHT;
      end else if (pending_q[IDX_DOWN]) begin
        grant_w[IDX_DOWN] = 1'b1;
        act_code_d        = CODE_DOWN;
      end else begin
        act_valid_d = 1'b0;
        act_code_d  = CODE_NONE;
      end
    end
  end

  assign pending_d = en ? ((pending_q & ~grant_w) | events_w) : 5'b0;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      prev_q      <= '0;
      pending_q   <= '0;
      dir_q       <= DIR_NONE;
      lr_cnt_q    <= '0;
      lr_das_q    <= 1'b0;
      dn_cnt_q    <= '0;
      act_valid_q <= 1'b0;
      act_code_q  <= CODE_NONE;
    end else begin
      prev_q      <= keys_w;
      pending_q   <= pending_d;
      dir_q       <= dir_d;
      lr_cnt_q    <= lr_cnt_d;
      lr_das_q    <= lr_das_d;
      dn_cnt_q    <= dn_cnt_d;
      act_valid_q <= act_valid_d;
      act_code_q  <= act_code_d;
    end
  end

  assign act_valid = act_valid_q;
  assign act_code  = act_code_q;

endmodule
